program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_pkg.sv | 28 ++
 rtl/program_loader.sv | 130 +++++++++++++
 tb/tb_program_loader.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: size defaults, the word limit
// and the loader state encoding.
package program_loader_pkg;

   localparam int ADDR_W_DEF  = 12;
   localparam int INSTR_W_DEF = 19;
   localparam int MAX_WORDS   = 4096;
   localparam int LEN_W       = 16;

   localparam logic [3:0] ST_IDLE   = 4'd0;
   localparam logic [3:0] ST_LEN_LO = 4'd1;
   localparam logic [3:0] ST_LEN_HI = 4'd2;
   localparam logic [3:0] ST_B0     = 4'd3;
   localparam logic [3:0] ST_B1     = 4'd4;
   localparam logic [3:0] ST_B2     = 4'd5;
   localparam logic [3:0] ST_WRITE  = 4'd6;
   localparam logic [3:0] ST_DONE   = 4'd7;
   localparam logic [3:0] ST_ERR    = 4'd8;

   function automatic logic accepts_byte(input logic [3:0] s);
      return s inside {ST_LEN_LO, ST_LEN_HI, ST_B0, ST_B1, ST_B2};
   endfunction

   function automatic logic is_loading(input logic [3:0] s);
      return s inside {ST_LEN_LO, ST_LEN_HI, ST_B0, ST_B1, ST_B2, ST_WRITE};
   endfunction

endpackage

// File: rtl/program_loader.sv
// Byte-stream program loader: a 16-bit word count followed by 3-byte
// little-endian instructions, written one per WRITE cycle into instruction memory.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// LEN_LO | capture word count bits [7:0]
// LEN_HI | capture word count bits [15:8], range-check the count
// B0     | capture instruction bits [7:0]
// B1     | capture instruction bits [15:8]
// B2     | capture instruction bits [18:16], upper byte bits must be zero
// WRITE  | one-cycle memory write of the assembled word
// DONE   | load complete, processor allowed to run
// ERR    | format error, processor held off until next start
module program_loader
   import program_loader_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int INSTR_W = INSTR_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               in_valid,
   input  logic [7:0]         in_data,
   output logic               in_ready,
   output logic               imem_we,
   output logic [ADDR_W-1:0]  imem_addr,
   output logic [INSTR_W-1:0] imem_wdata,
   output logic               busy,
   output logic               done,
   output logic               error,
   output logic               cpu_run
);

   localparam int IDX_W = ADDR_W + 1;

   logic [3:0]         state;
   logic [3:0]         state_nxt;
   logic [LEN_W-1:0]   len;
   logic [IDX_W-1:0]   index;
   logic [INSTR_W-1:0] word;

   logic             xfer;
   logic [LEN_W-1:0] len_full;
   logic             len_too_big;
   logic             last_word;
   logic             hi_bits_bad;

   // in_ready is a pure state decode, so it never depends on in_valid
   assign in_ready    = accepts_byte(state);
   assign xfer        = in_valid & in_ready;
   assign len_full    = {in_data, len[7:0]};
   assign len_too_big = len_full > LEN_W'(MAX_WORDS);
   assign last_word   = (LEN_W'(index) + LEN_W'(1)) == len;
   assign hi_bits_bad = |in_data[7:INSTR_W-16];

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) state_nxt = ST_LEN_LO;
         end
         ST_LEN_LO: begin
            if (xfer) state_nxt = ST_LEN_HI;
         end
         ST_LEN_HI: begin
            if (xfer) begin
               if (len_full == '0)
                  state_nxt = ST_DONE;
               else if (len_too_big)
                  state_nxt = ST_ERR;
               else
                  state_nxt = ST_B0;
            end
         end
         ST_B0: begin
            if (xfer) state_nxt = ST_B1;
         end
         ST_B1: begin
            if (xfer) state_nxt = ST_B2;
         end
         ST_B2: begin
            if (xfer) state_nxt = hi_bits_bad ? ST_ERR : ST_WRITE;
         end
         ST_WRITE: begin
            state_nxt = last_word ? ST_DONE : ST_B0;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         len   <= '0;
         index <= '0;
         word  <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (start) begin
                  len   <= '0;
                  index <= '0;
                  word  <= '0;
               end
            end
            ST_LEN_LO: if (xfer) len[7:0]  <= in_data;
            ST_LEN_HI: if (xfer) len[15:8] <= in_data;
            ST_B0:     if (xfer) word[7:0]  <= in_data;
            ST_B1:     if (xfer) word[15:8] <= in_data;
            ST_B2:     if (xfer) word[INSTR_W-1:16] <= in_data[INSTR_W-17:0];
            ST_WRITE: begin
               // index stops on the last word so a 4096-word load ends at 4095
               if (!last_word) index <= index + IDX_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign imem_we    = (state == ST_WRITE);
   assign imem_addr  = index[ADDR_W-1:0];
   assign imem_wdata = word;
   assign busy       = is_loading(state);
   assign done       = (state == ST_DONE);
   assign error      = (state == ST_ERR);
   assign cpu_run    = (state == ST_DONE);

endmodule

// File: tb/tb_program_loader.sv
// Directed and randomized bench for program_loader; expected memory images
// and load latencies come from the word lists fed to the stream.
module tb_program_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        imem_we;
   logic [11:0] imem_addr;
   logic [18:0] imem_wdata;
   logic        busy;
   logic        done;
   logic        error;
   logic        cpu_run;

   int nchk = 0;
   int npass = 0;
   int cyc = 0;
   int t_start = 0;

   typedef struct {
      logic [11:0] a;
      logic [18:0] d;
   } wr_t;
   wr_t wrq[$];

   program_loader dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .busy(busy), .done(done), .error(error),
      .cpu_run(cpu_run)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         wr_t w;
         w.a = imem_addr;
         w.d = imem_wdata;
         wrq.push_back(w);
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; start = 1'b0; in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      t_start = cyc;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gaps, input bit ps);
      int cnt;
      if (gaps > 0) begin
         repeat ($urandom_range(0, gaps)) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
         end
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      if (ps) start = 1'b1;
      cnt = 0;
      while (in_ready !== 1'b1 && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      if (cnt >= 50) begin
         check("in_ready_timeout", 0, 1);
         in_valid = 1'b0;
         start = 1'b0;
         return;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      start = 1'b0;
   endtask

   task automatic make_stream(input logic [18:0] w[$], output logic [7:0] s[$]);
      int n;
      n = w.size();
      s.delete();
      s.push_back(8'(n));
      s.push_back(8'(n >> 8));
      foreach (w[i]) begin
         s.push_back(w[i][7:0]);
         s.push_back(w[i][15:8]);
         s.push_back({5'b0, w[i][18:16]});
      end
   endtask

   task automatic send_stream(input logic [7:0] s[$], input int gaps, input int ps_idx);
      foreach (s[i]) send_byte(s[i], gaps, i == ps_idx);
   endtask

   task automatic wait_end(output int at);
      int cnt;
      cnt = 0;
      at = -1;
      while (cnt < 200) begin
         @(negedge clk);
         if (done === 1'b1 || error === 1'b1) begin
            at = cyc;
            break;
         end
         cnt++;
      end
      if (at < 0) check("end_timeout", 0, 1);
   endtask

   task automatic check_load(input string tag, input logic [18:0] w[$]);
      int bad;
      bad = 0;
      check({tag, "_nwrites"}, wrq.size(), w.size());
      foreach (wrq[i])
         if (i >= w.size() || wrq[i].a !== 12'(i) || wrq[i].d !== w[i]) bad++;
      check({tag, "_image"}, bad, 0);
   endtask

   task automatic rand_words(input int n, output logic [18:0] w[$]);
      w.delete();
      repeat (n) w.push_back(19'($urandom));
   endtask

   initial begin
      logic [18:0] w[$];
      logic [7:0]  s[$];
      int t;

      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      do_reset();
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_cpu_run", cpu_run, 0);
      check("rst_imem_we", imem_we, 0);
      check("rst_imem_addr", imem_addr, 0);
      check("rst_imem_wdata", imem_wdata, 0);

      // two-word reference stream
      wrq.delete();
      pulse_start();
      check("t1_busy_after_start", busy, 1);
      check("t1_ready_after_start", in_ready, 1);
      w = '{19'h51234, 19'h300FF};
      make_stream(w, s);
      check("t1_stream_byte4", s[4], 8'h05);
      send_stream(s, 0, -1);
      wait_end(t);
      check("t1_latency", t - t_start, 2 + 4 * 2);
      check("t1_done", done, 1);
      check("t1_cpu_run", cpu_run, 1);
      check("t1_error", error, 0);
      check("t1_busy", busy, 0);
      check_load("t1", w);

      // zero-length load
      wrq.delete();
      pulse_start();
      check("t2_done_cleared", done, 0);
      check("t2_cpu_run_cleared", cpu_run, 0);
      send_stream('{8'h00, 8'h00}, 0, -1);
      wait_end(t);
      check("t2_latency", t - t_start, 2);
      check("t2_done", done, 1);
      check("t2_cpu_run", cpu_run, 1);
      check("t2_nwrites", wrq.size(), 0);

      // over-length count, then a clean reload
      wrq.delete();
      pulse_start();
      send_stream('{8'h01, 8'h10}, 0, -1);
      wait_end(t);
      check("t3_error", error, 1);
      check("t3_cpu_run", cpu_run, 0);
      check("t3_done", done, 0);
      repeat (5) @(negedge clk);
      check("t3_error_sticky", error, 1);
      check("t3_nwrites", wrq.size(), 0);
      rand_words(3, w);
      make_stream(w, s);
      pulse_start();
      check("t3_error_cleared", error, 0);
      send_stream(s, 0, -1);
      wait_end(t);
      check("t3_reload_done", done, 1);
      check("t3_reload_error", error, 0);
      check_load("t3_reload", w);

      // bad upper bits in the third byte, then a reload using bits [18:16]=7
      wrq.delete();
      pulse_start();
      send_stream('{8'h01, 8'h00, 8'h34, 8'h12, 8'h08}, 0, -1);
      wait_end(t);
      check("t4_error", error, 1);
      check("t4_cpu_run", cpu_run, 0);
      check("t4_nwrites", wrq.size(), 0);
      w = '{{3'h7, 16'($urandom)}};
      make_stream(w, s);
      check("t4_stream_byte4", s[4], 8'h07);
      pulse_start();
      send_stream(s, 0, -1);
      wait_end(t);
      check("t4_reload_done", done, 1);
      check_load("t4_reload", w);
      if (wrq.size() > 0) check("t4_top_bits", wrq[0].d[18:16], 3'h7);

      // 16 words with random stalls and a stray start pulse mid-load
      wrq.delete();
      rand_words(16, w);
      make_stream(w, s);
      pulse_start();
      send_stream(s, 3, 20);
      wait_end(t);
      check("t5_done", done, 1);
      check("t5_cpu_run", cpu_run, 1);
      check_load("t5", w);

      // maximum length: addresses 0..4095 with no wrap
      wrq.delete();
      rand_words(4096, w);
      make_stream(w, s);
      pulse_start();
      send_stream(s, 0, -1);
      wait_end(t);
      check("t6_latency", t - t_start, 2 + 4 * 4096);
      check("t6_done", done, 1);
      check_load("t6", w);
      if (wrq.size() > 0) check("t6_last_addr", wrq[wrq.size()-1].a, 12'd4095);

      // reset while word 3 is being assembled
      wrq.delete();
      rand_words(8, w);
      make_stream(w, s);
      pulse_start();
      for (int i = 0; i < 2 + 3 * 3 + 1; i++) send_byte(s[i], 0, 1'b0);
      @(negedge clk);
      check("t7_ready_in_b1", in_ready, 1);
      rst = 1'b1;
      in_valid = 1'b1;
      in_data = s[12];
      @(posedge clk);
      #1;
      check("t7_busy", busy, 0);
      check("t7_in_ready", in_ready, 0);
      check("t7_imem_we", imem_we, 0);
      check("t7_done", done, 0);
      check("t7_error", error, 0);
      check("t7_cpu_run", cpu_run, 0);
      check("t7_imem_addr", imem_addr, 0);
      check("t7_imem_wdata", imem_wdata, 0);
      rst = 1'b0;
      repeat (10) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data = 8'($urandom);
      end
      in_valid = 1'b0;
      @(negedge clk);
      check("t7_still_idle", busy, 0);
      check_load("t7", w[0:2]);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
